hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit
//  Description : Five-stage pipeline hazard unit. Operand forwarding selects,
//                load-use stall, branch flush, data-memory freeze with a
//                wait-limit watchdog, and saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_branch_taken,
  input  logic [4:0]       ex_mem_rd,
  input  logic [4:0]       mem_wb_rd,
  input  logic             ex_mem_reg_write,
  input  logic             mem_wb_reg_write,
  input  logic             ex_mem_mem_req,
  input  logic             dmem_ready,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  // One extra bit so the counter can sit at MAX_WAIT+1 without wrapping.
  localparam int             WL_W      = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [WL_W-1:0] C_WAIT_LIM = WL_W'(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WL_W-1:0] r_wait_len;
  logic [WL_W-1:0] w_wait_len_next;
  logic            w_freeze;
  logic            w_load_use;
  logic            w_branch;
  logic            w_lu_stall;

  // MEM stage holds the newer value, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs))
      return 2'b10;
    else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign forward_a  = fwd_sel(id_ex_rs1);
  assign forward_b  = fwd_sel(id_ex_rs2);

  assign w_freeze   = ex_mem_mem_req && !dmem_ready;
  assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  // Branch flush is deferred while frozen: ID/EX holds, so it reapplies later.
  assign w_branch   = !w_freeze && id_ex_branch_taken;
  assign w_lu_stall = !w_freeze && !id_ex_branch_taken && w_load_use;

  // Pipeline control with priority freeze > branch > load-use > normal.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (w_freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (id_ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Wait FSM next state and wait-length next value.
  always_comb begin
    w_state_next    = r_state;
    w_wait_len_next = '0;
    case (r_state)
      ST_IDLE: if (w_freeze) w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (w_freeze) begin
          w_wait_len_next = (r_wait_len == C_WAIT_LIM) ? r_wait_len
                                                       : r_wait_len + 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Wait FSM state, wait length and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wait_len  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_len <= w_wait_len_next;
      if (w_wait_len_next == C_WAIT_LIM) mem_timeout <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
      wait_cnt     <= '0;
    end else begin
      if (w_lu_stall && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + 1'b1;
      if (w_branch   && (flush_cnt    != '1)) flush_cnt    <= flush_cnt + 1'b1;
      if (w_freeze   && (wait_cnt     != '1)) wait_cnt     <= wait_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_unit
//  Description : Scoreboard bench for hazard_forward_unit (MAX_WAIT=4,
//                CNT_W=4) with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

  localparam int         MAX_WAIT = 4;
  localparam int         CNT_W    = 4;
  localparam int         CMAX     = 15;
  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] NORM = 7'b1111_000;
  localparam logic [6:0] LU   = 7'b0011_010;
  localparam logic [6:0] BR   = 7'b1111_110;
  localparam logic [6:0] FRZ  = 7'b0000_001;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic id_ex_mem_read, id_ex_branch_taken, ex_mem_reg_write, mem_wb_reg_write;
  logic ex_mem_mem_req, dmem_ready;
  logic [1:0] forward_a, forward_b;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
  logic [CNT_W-1:0] lu_stall_cnt, flush_cnt, wait_cnt;

  hazard_forward_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_branch_taken(id_ex_branch_taken),
    .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
    .ex_mem_mem_req(ex_mem_mem_req), .dmem_ready(dmem_ready),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] fwd;
    logic [6:0] ctl;
    int         lu;
    int         fl;
    int         wt;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_lu  = 0;
  int   exp_fl  = 0;
  int   exp_wt  = 0;
  logic exp_to  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected response for the current cycle; cls 1=load-use stall, 2=flush, 3=freeze.
  task automatic push(input string name, input logic [3:0] fwd, input logic [6:0] ctl, input int cls);
    exp_t e;
    e.name = name; e.fwd = fwd; e.ctl = ctl;
    e.lu = exp_lu; e.fl = exp_fl; e.wt = exp_wt; e.to = exp_to;
    sb.push_back(e);
    if (reset_n) begin
      if (cls == 1 && exp_lu < CMAX) exp_lu++;
      if (cls == 2 && exp_fl < CMAX) exp_fl++;
      if (cls == 3 && exp_wt < CMAX) exp_wt++;
    end
  endtask

  task automatic clr();
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rs1 = 0; id_ex_rs2 = 0; id_ex_rd = 0;
    ex_mem_rd = 0; mem_wb_rd = 0; id_ex_mem_read = 0; id_ex_branch_taken = 0;
    ex_mem_reg_write = 0; mem_wb_reg_write = 0; ex_mem_mem_req = 0; dmem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, " fwd"}, {28'd0, forward_a, forward_b}, {28'd0, e.fwd});
      chk({e.name, " ctl"}, {25'd0, pc_write, if_id_write, id_ex_write, ex_mem_write,
                             if_id_flush, id_ex_flush, mem_wb_bubble}, {25'd0, e.ctl});
      chk({e.name, " cnt"}, {20'd0, lu_stall_cnt, 4'd0, flush_cnt, wait_cnt},
          {20'd0, e.lu[3:0], 4'd0, e.fl[3:0], e.wt[3:0]});
      chk({e.name, " timeout"}, {31'd0, mem_timeout}, {31'd0, e.to});
    end
  end

  initial begin
    int t;
    reset_n = 1'b0;
    clr();
    cyc(); push("rst_idle", 4'b0000, NORM, 0);
    cyc(); id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs1 = 7;
    push("rst_comb_lu", 4'b0000, LU, 1);
    @(negedge clk); #1; reset_n = 1'b1; clr();

    // Forwarding
    cyc(); id_ex_rs1 = 5; ex_mem_rd = 5; ex_mem_reg_write = 1; mem_wb_rd = 5; mem_wb_reg_write = 1;
    push("fwd_mem_prio", 4'b1000, NORM, 0);
    cyc(); ex_mem_reg_write = 0; push("fwd_wb", 4'b0100, NORM, 0);
    cyc(); ex_mem_reg_write = 1; ex_mem_rd = 0; mem_wb_rd = 0; push("fwd_rd0", 4'b0000, NORM, 0);
    cyc(); id_ex_rs1 = 1; id_ex_rs2 = 2; ex_mem_rd = 2; mem_wb_rd = 1;
    push("fwd_split", 4'b0110, NORM, 0);
    cyc(); id_ex_rs1 = 9; id_ex_rs2 = 9; ex_mem_rd = 9; mem_wb_rd = 9;
    push("fwd_both_mem", 4'b1010, NORM, 0);

    // Load-use
    cyc(); clr(); id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs2 = 7; push("lu_stall", 4'b0000, LU, 1);
    cyc(); clr(); push("lu_after", 4'b0000, NORM, 0);
    cyc(); id_ex_mem_read = 1; id_ex_rd = 0; push("lu_rd0", 4'b0000, NORM, 0);

    // Branch beats load-use
    cyc(); clr(); id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs1 = 7; id_ex_branch_taken = 1;
    push("br_over_lu", 4'b0000, BR, 2);
    cyc(); clr(); push("br_after", 4'b0000, NORM, 0);

    // Memory wait with deferred branch
    for (int i = 0; i < 3; i++) begin
      cyc(); ex_mem_mem_req = 1; dmem_ready = 0; id_ex_branch_taken = 1;
      push("frz_br", 4'b0000, FRZ, 3);
    end
    cyc(); dmem_ready = 1; push("frz_release_br", 4'b0000, BR, 2);
    cyc(); clr(); push("frz_after", 4'b0000, NORM, 0);

    // Timeout: six freeze cycles, flag appears after the sixth edge
    for (int i = 0; i < 6; i++) begin
      cyc(); ex_mem_mem_req = 1; dmem_ready = 0; push("to_frz", 4'b0000, FRZ, 3);
    end
    exp_to = 1'b1;
    cyc(); clr(); push("to_sticky1", 4'b0000, NORM, 0);
    cyc(); push("to_sticky2", 4'b0000, NORM, 0);

    // Asynchronous reset in the middle of a wait
    for (int i = 0; i < 2; i++) begin
      cyc(); ex_mem_mem_req = 1; push("rst_wait_frz", 4'b0000, FRZ, 3);
    end
    @(negedge clk); #2; reset_n = 1'b0; #1;
    chk("async_rst lu", {28'd0, lu_stall_cnt}, 32'd0);
    chk("async_rst fl", {28'd0, flush_cnt}, 32'd0);
    chk("async_rst wt", {28'd0, wait_cnt}, 32'd0);
    chk("async_rst to", {31'd0, mem_timeout}, 32'd0);
    exp_lu = 0; exp_fl = 0; exp_wt = 0; exp_to = 1'b0;
    cyc(); push("rst_comb_frz", 4'b0000, FRZ, 3);
    @(negedge clk); #1; reset_n = 1'b1; clr();

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      cyc(); id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs1 = 3; push("lu_sat", 4'b0000, LU, 1);
    end
    cyc(); clr(); push("lu_sat_final", 4'b0000, NORM, 0);
    chk("lu_sat_model", exp_lu, 32'd15);

    t = 0;
    while (sb.size() > 0 && t < 10) begin
      @(posedge clk);
      t++;
    end
    chk("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
